elevator: RTL and testbench
===========================

ELEVATOR -- requirements
Module: elevator

Interface
REQ-001 SHALL have parameter FLOORS, default 5, number of floors (floor indices 0..FLOORS-1).
REQ-002 SHALL have parameter POS_W, default 3, width of the floor position; it must satisfy 2**POS_W >= FLOORS.
REQ-003 SHALL have parameter DOOR_CYCLES, default 3, number of clock cycles door_open stays high per stop (must be >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port floor_req, input, FLOORS bits: one-hot or multi-hot call pulses; bit i requests floor i.
REQ-007 SHALL have port floor_pos, output, POS_W bits: current floor index, registered.
REQ-008 SHALL have port door_open, output, 1 bit: door open, registered.
REQ-009 SHALL have port moving_up, output, 1 bit: car travelling up, registered.
REQ-010 SHALL have port moving_dn, output, 1 bit: car travelling down, registered.

Function
REQ-011 SHALL latch requests into a pending register on every rising edge: pend <= (pend | floor_req) & ~clear. A one-cycle pulse is sufficient, and repeated pulses for an already-pending floor have no further effect.
REQ-012 SHALL use a state machine with four states: IDLE, MOVE_UP, MOVE_DN, DOOR. It SHALL also keep a direction register dir (UP/DN) that holds the last travel direction.
REQ-013 IDLE: if pend[floor_pos] is set, the FSM SHALL go to DOOR, clear that bit and load the door timer.
REQ-014 IDLE, otherwise: if requests are pending in the dir direction, the FSM SHALL move in dir. If not, but requests are pending in the opposite direction, it SHALL reverse dir and move. If nothing is pending, it SHALL stay in IDLE.
REQ-015 SHALL make decisions using registered pend only, so a request pulse sampled at edge E can be acted on no earlier than edge E+1.
REQ-016 MOVE_UP: each cycle floor_pos SHALL increment by exactly 1. If pend[new floor_pos] is set, the same edge SHALL enter DOOR and clear that bit; otherwise the FSM SHALL stay in MOVE_UP. MOVE_DN SHALL mirror this with decrement.
REQ-017 SHALL never let floor_pos leave the range 0..FLOORS-1. A move SHALL be started only toward a pending floor, so the boundary floors are always stopping points.
REQ-018 DOOR: door_open SHALL be 1 for exactly DOOR_CYCLES consecutive cycles. After that the FSM SHALL return to IDLE with door_open=0, and the next decision follows REQ-013/014 (scan/collective policy).
REQ-019 A request for floor_pos that arrives while the FSM is in DOOR SHALL be absorbed: it is cleared and the timer is not extended.
REQ-020 Requests for other floors arriving in any state SHALL be latched and serviced later.
REQ-021 Outputs SHALL be derived from the state: moving_up=1 only in MOVE_UP, moving_dn=1 only in MOVE_DN, door_open=1 only in DOOR. At most one of the three is high at a time.
REQ-022 SHALL treat simultaneous requests above and below the car as follows: the current dir takes priority, and the other side is served after reversal.

Reset
REQ-023 When reset=1 at a rising edge: state <= IDLE, floor_pos <= 0, pend <= 0, dir <= UP, door timer <= 0, and door_open, moving_up and moving_dn are all 0.
REQ-024 Reset SHALL take priority over all other activity, including mid-move or door-open. Requests presented during reset SHALL be discarded.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE, MOVE_UP, MOVE_DN, DOOR) and the direction constants. Parameters stay on the module.
REQ-026 One sub-module, elevator_req_sched, SHALL be used. It holds the pending register and produces the combinational signals req_here, req_above and req_below from pend and floor_pos.
REQ-027 The door timer SHALL be a counter of width clog2(DOOR_CYCLES+1) inside elevator.

Verification
REQ-028 Single call: reset, then pulse floor_req=01000 at edge E0. Required response: moving_up=1 after E1; floor_pos=1,2,3 after E2,E3,E4; door_open=1 after E4 through E6; IDLE with all outputs 0 after E7.
REQ-029 Multi call: at floor 3, idle with dir=UP, pulse 10010. Required response: car goes up to 4 with a 3-cycle door, then down 3→2→1 with a 3-cycle door at 1, then IDLE.
REQ-030 Dynamic call: from floor 1, pulse 00100 (floor 2); two cycles later pulse 10001. Required response: stop at 2, continue up to 4, then reverse down to 0; each stop opens the door for exactly 3 cycles.
REQ-031 Current-floor call while idle: at floor 0, pulse 00001. Required response: door_open=1 one cycle after the sampling edge, for 3 cycles, with no movement.
REQ-032 Spam: pulse floor 1 three times on consecutive pulses while the car is elsewhere. Required response: exactly one stop at floor 1, and pend[1]=0 afterward.
REQ-033 Mid-move reset: assert reset while MOVE_UP at floor 2. Required response: next edge gives floor_pos=0, all outputs 0, pend=0. Also check the invariants throughout: never two outputs high at once, and floor_pos <= FLOORS-1.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller.
//   state_e : controller states (IDLE, MOVE_UP, MOVE_DN, DOOR)
//   dir_e   : remembered travel direction (DIR_UP, DIR_DN)
// Floor count, position width and door time are parameters on the modules.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

endpackage

// File: rtl/elevator_req_sched.sv
// Pending-call register and request summary for the elevator.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   floor_req   : call pulses, bit i = floor i (multi-hot allowed)
//   clear       : floors being serviced this cycle; clear wins over a new call
//   floor_pos   : current car floor
//   pend        : registered pending calls
//   req_here    : a call is pending at floor_pos
//   req_above   : a call is pending above floor_pos
//   req_below   : a call is pending below floor_pos
// The req_* outputs look only at the registered pend, so a call pulse
// cannot influence a decision on the edge that samples it.
module elevator_req_sched
    import elevator_pkg::*;
#(
    parameter int FLOORS = 5,
    parameter int POS_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] floor_req,
    input  logic [FLOORS-1:0] clear,
    input  logic [POS_W-1:0]  floor_pos,
    output logic [FLOORS-1:0] pend,
    output logic              req_here,
    output logic              req_above,
    output logic              req_below
);

    logic [FLOORS-1:0] pend_d, pend_q;

    // A call for a floor being cleared on the same edge is absorbed.
    always_comb begin
        pend_d = (pend_q | floor_req) & ~clear;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        req_here  = 1'b0;
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i == int'(floor_pos)) req_here  = req_here  | pend_q[i];
            if (i >  int'(floor_pos)) req_above = req_above | pend_q[i];
            if (i <  int'(floor_pos)) req_below = req_below | pend_q[i];
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/elevator.sv
// Single-car elevator controller with a scan (collective) policy: keep
// going in the remembered direction while calls remain that way, then
// reverse. The car moves one floor per cycle and holds the door open for
// DOOR_CYCLES cycles at each stop.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   floor_req  : call pulses, bit i = floor i
//   floor_pos  : current floor (registered)
//   door_open  : high only in DOOR
//   moving_up  : high only in MOVE_UP
//   moving_dn  : high only in MOVE_DN
module elevator
    import elevator_pkg::*;
#(
    parameter int FLOORS      = 5,
    parameter int POS_W       = 3,
    parameter int DOOR_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] floor_req,
    output logic [POS_W-1:0]  floor_pos,
    output logic              door_open,
    output logic              moving_up,
    output logic              moving_dn
);

    localparam int TMR_W = $clog2(DOOR_CYCLES + 1);

    state_e            state_d, state_q;
    dir_e              dir_d, dir_q;
    logic [POS_W-1:0]  floor_pos_d, floor_pos_q;
    logic [TMR_W-1:0]  tmr_d, tmr_q;
    logic [FLOORS-1:0] clear;
    logic [FLOORS-1:0] pend;
    logic              req_here, req_above, req_below;
    logic [POS_W-1:0]  pos_up, pos_dn;
    logic              pend_up, pend_dn;

    function automatic logic [FLOORS-1:0] floor_mask(input logic [POS_W-1:0] p);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) begin
            m[i] = (int'(p) == i);
        end
        return m;
    endfunction

    elevator_req_sched #(
        .FLOORS (FLOORS),
        .POS_W  (POS_W)
    ) u_sched (
        .clk       (clk),
        .reset     (reset),
        .floor_req (floor_req),
        .clear     (clear),
        .floor_pos (floor_pos_q),
        .pend      (pend),
        .req_here  (req_here),
        .req_above (req_above),
        .req_below (req_below)
    );

    // Neighbouring floors and whether a call waits there; only consulted
    // while moving toward them.
    assign pos_up  = floor_pos_q + POS_W'(1);
    assign pos_dn  = floor_pos_q - POS_W'(1);
    assign pend_up = |(pend & floor_mask(pos_up));
    assign pend_dn = |(pend & floor_mask(pos_dn));

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        floor_pos_d = floor_pos_q;
        tmr_d       = tmr_q;
        clear       = '0;
        case (state_q)
            IDLE: begin
                if (req_here) begin
                    state_d = DOOR;
                    clear   = floor_mask(floor_pos_q);
                    tmr_d   = TMR_W'(DOOR_CYCLES);
                end else if (dir_q == DIR_UP) begin
                    if (req_above) begin
                        state_d = MOVE_UP;
                    end else if (req_below) begin
                        dir_d   = DIR_DN;
                        state_d = MOVE_DN;
                    end
                end else begin
                    if (req_below) begin
                        state_d = MOVE_DN;
                    end else if (req_above) begin
                        dir_d   = DIR_UP;
                        state_d = MOVE_UP;
                    end
                end
            end
            MOVE_UP: begin
                // A move only starts toward a pending floor, so the top
                // floor is always a stop; the guard just keeps floor_pos
                // in range should that ever not hold.
                if (int'(floor_pos_q) >= FLOORS - 1) begin
                    state_d = IDLE;
                end else begin
                    floor_pos_d = pos_up;
                    if (pend_up) begin
                        state_d = DOOR;
                        clear   = floor_mask(pos_up);
                        tmr_d   = TMR_W'(DOOR_CYCLES);
                    end
                end
            end
            MOVE_DN: begin
                if (floor_pos_q == '0) begin
                    state_d = IDLE;
                end else begin
                    floor_pos_d = pos_dn;
                    if (pend_dn) begin
                        state_d = DOOR;
                        clear   = floor_mask(pos_dn);
                        tmr_d   = TMR_W'(DOOR_CYCLES);
                    end
                end
            end
            DOOR: begin
                // Calls for this floor while the door is open are swallowed
                // without extending the timer.
                clear = floor_mask(floor_pos_q);
                if (tmr_q <= TMR_W'(1)) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            dir_q       <= DIR_UP;
            floor_pos_q <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            floor_pos_q <= floor_pos_d;
            tmr_q       <= tmr_d;
        end
    end

    assign floor_pos = floor_pos_q;
    assign door_open = (state_q == DOOR);
    assign moving_up = (state_q == MOVE_UP);
    assign moving_dn = (state_q == MOVE_DN);

endmodule

// File: tb/tb_elevator.sv
// Scoreboard bench for the elevator controller. Stimulus pushes the
// hand-derived per-cycle output trace, stamped with the clock cycle it
// belongs to; a monitor on the falling edge pops and compares entries
// as their cycle comes up, and also checks the output invariants.
module tb_elevator;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] floor_req = '0;
    logic [2:0] floor_pos;
    logic       door_open, moving_up, moving_dn;

    elevator #(
        .FLOORS      (5),
        .POS_W       (3),
        .DOOR_CYCLES (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .floor_req (floor_req),
        .floor_pos (floor_pos),
        .door_open (door_open),
        .moving_up (moving_up),
        .moving_dn (moving_dn)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] pos;
        logic       door;
        logic       up;
        logic       dn;
        bit         chk_pend;
        string      name;
    } exp_t;

    exp_t  sb[$];
    int    cyc = 0;
    int    base = 0;
    int    total = 0;
    int    bad = 0;
    bit    inv_on = 1'b0;
    string scen = "none";

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor: compares whatever the scoreboard expects for this cycle.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (inv_on) begin
            total = total + 1;
            if ((int'(door_open) + int'(moving_up) + int'(moving_dn)) > 1 || floor_pos > 3'd4) begin
                bad = bad + 1;
                $display("FAIL invariant cyc=%0d got pos=%0d door=%b up=%b dn=%b, need pos<=4 and at most one output high",
                         cyc, floor_pos, door_open, moving_up, moving_dn);
            end
        end
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total = total + 1;
            if (e.cyc != cyc || floor_pos !== e.pos || door_open !== e.door ||
                moving_up !== e.up || moving_dn !== e.dn) begin
                bad = bad + 1;
                $display("FAIL %s cyc=%0d (want cyc %0d) got pos=%0d door=%b up=%b dn=%b need pos=%0d door=%b up=%b dn=%b",
                         e.name, cyc, e.cyc, floor_pos, door_open, moving_up, moving_dn,
                         e.pos, e.door, e.up, e.dn);
            end
            if (e.chk_pend) begin
                total = total + 1;
                if (dut.pend !== 5'b00000) begin
                    bad = bad + 1;
                    $display("FAIL %s_pend cyc=%0d got pend=%b need 00000", e.name, cyc, dut.pend);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic push(input int k, input logic [2:0] p, input logic d, input logic u,
                        input logic n, input bit cp);
        exp_t e;
        e.cyc = base + k;
        e.pos = p;
        e.door = d;
        e.up = u;
        e.dn = n;
        e.chk_pend = cp;
        e.name = scen;
        sb.push_back(e);
    endtask

    // Expected outputs after edge E<k> of the current scenario.
    task automatic ex(input int k, input logic [2:0] p, input logic d, input logic u, input logic n);
        push(k, p, d, u, n, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a call pulse to be sampled at the next edge (E0).
    task automatic start(input logic [4:0] req);
        step();
        floor_req = req;
        base = cyc + 1;
    endtask

    task automatic do_reset();
        scen = "reset";
        step();
        reset = 1'b1;
        floor_req = 5'b00100;  // must be discarded
        step();
        base = cyc;
        push(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        floor_req = '0;
        inv_on = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        do_reset();

        // Single call to floor 3 from floor 0.
        scen = "single";
        start(5'b01000);
        ex(0, 0, 0, 0, 0); ex(1, 0, 0, 1, 0); ex(2, 1, 0, 1, 0); ex(3, 2, 0, 1, 0);
        ex(4, 3, 1, 0, 0); ex(5, 3, 1, 0, 0); ex(6, 3, 1, 0, 0); ex(7, 3, 0, 0, 0);
        step(); floor_req = '0;
        repeat (9) step();

        // Floor 3, dir UP: calls 4 and 1 -> up to 4, then down to 1.
        scen = "multi";
        start(5'b10010);
        ex(0, 3, 0, 0, 0); ex(1, 3, 0, 1, 0); ex(2, 4, 1, 0, 0); ex(3, 4, 1, 0, 0);
        ex(4, 4, 1, 0, 0); ex(5, 4, 0, 0, 0); ex(6, 4, 0, 0, 1); ex(7, 3, 0, 0, 1);
        ex(8, 2, 0, 0, 1); ex(9, 1, 1, 0, 0); ex(10, 1, 1, 0, 0); ex(11, 1, 1, 0, 0);
        ex(12, 1, 0, 0, 0);
        step(); floor_req = '0;
        repeat (14) step();

        // Floor 1: call 2, then 4 and 0 two cycles later.
        scen = "dynamic";
        start(5'b00100);
        ex(0, 1, 0, 0, 0); ex(1, 1, 0, 1, 0); ex(2, 2, 1, 0, 0); ex(3, 2, 1, 0, 0);
        ex(4, 2, 1, 0, 0); ex(5, 2, 0, 0, 0); ex(6, 2, 0, 1, 0); ex(7, 3, 0, 1, 0);
        ex(8, 4, 1, 0, 0); ex(9, 4, 1, 0, 0); ex(10, 4, 1, 0, 0); ex(11, 4, 0, 0, 0);
        ex(12, 4, 0, 0, 1); ex(13, 3, 0, 0, 1); ex(14, 2, 0, 0, 1); ex(15, 1, 0, 0, 1);
        ex(16, 0, 1, 0, 0); ex(17, 0, 1, 0, 0); ex(18, 0, 1, 0, 0); ex(19, 0, 0, 0, 0);
        step(); floor_req = '0;            // after E0
        step(); floor_req = 5'b10001;      // sampled at E2
        step(); floor_req = '0;
        repeat (19) step();

        // Call at the current floor; a repeat during the door is absorbed.
        scen = "here";
        start(5'b00001);
        ex(0, 0, 0, 0, 0); ex(1, 0, 1, 0, 0); ex(2, 0, 1, 0, 0); ex(3, 0, 1, 0, 0);
        ex(4, 0, 0, 0, 0); ex(5, 0, 0, 0, 0); ex(6, 0, 0, 0, 0);
        step(); floor_req = '0;            // after E0
        step(); floor_req = 5'b00001;      // sampled at E2, door open
        step(); floor_req = '0;
        repeat (6) step();

        // Floor 1 called on three consecutive edges: one stop only.
        scen = "spam";
        start(5'b00010);
        ex(0, 0, 0, 0, 0); ex(1, 0, 0, 1, 0); ex(2, 1, 1, 0, 0); ex(3, 1, 1, 0, 0);
        ex(4, 1, 1, 0, 0); ex(5, 1, 0, 0, 0);
        push(6, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        ex(7, 1, 0, 0, 0);
        step();
        step();
        step(); floor_req = '0;
        repeat (8) step();

        // Reset while moving up past floor 2.
        scen = "midreset";
        start(5'b10000);
        ex(0, 1, 0, 0, 0); ex(1, 1, 0, 1, 0); ex(2, 2, 0, 1, 0);
        push(3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        ex(4, 0, 0, 0, 0); ex(5, 0, 0, 0, 0);
        step(); floor_req = '0;            // after E0
        step();                            // after E1
        step(); reset = 1'b1;              // after E2, sampled at E3
        step(); reset = 1'b0;
        repeat (4) step();

        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL drain got %0d unchecked entries need 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
